// File: rtl/alu_scheduler_if.sv
`default_nettype none
// alu_scheduler_if: requester, response and ALU-side signals of the ALU scheduler.
// Rev 1.0
interface alu_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4
);
  logic                  req0_valid;
  logic                  req1_valid;
  logic                  req0_ready;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [OP_WIDTH-1:0]   req0_op;
  logic [OP_WIDTH-1:0]   req1_op;
  logic                  rsp0_valid;
  logic                  rsp1_valid;
  logic                  rsp0_ready;
  logic                  rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [DATA_WIDTH-1:0] alu_in_a;
  logic [DATA_WIDTH-1:0] alu_in_b;
  logic [OP_WIDTH-1:0]   alu_op_code;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  busy;

  // Requesters and the ALU instance together form the master side.
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
    input  alu_in_a, alu_in_b, alu_op_code, busy
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
    output alu_in_a, alu_in_b, alu_op_code, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_scheduler.sv
`default_nettype none
// alu_scheduler: round-robin sharing of one registered ALU between two requesters.
// Rev 1.0
module alu_scheduler #(
  parameter int DATA_WIDTH  = 8,
  parameter int OP_WIDTH    = 4,
  parameter int ALU_LATENCY = 1
) (
  input  wire logic CLK,
  input  wire logic RESET,
  alu_scheduler_if.slave bus
);
  localparam int CNT_WIDTH = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(ALU_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  if (ALU_LATENCY < 1) begin : g_bad_latency
    $error("alu_scheduler: ALU_LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic                  pri;
  logic                  owner;
  logic [DATA_WIDTH-1:0] lat_a;
  logic [DATA_WIDTH-1:0] lat_b;
  logic [OP_WIDTH-1:0]   lat_op;
  logic [DATA_WIDTH-1:0] result;
  logic [CNT_WIDTH-1:0]  cnt;

  logic grant;
  logic req0_ready;
  logic req1_ready;
  logic accept;
  logic rsp0_valid;
  logic rsp1_valid;
  logic rsp_fire;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      IDLE: begin
        // Contention is settled by the pointer; a lone requester always wins.
        if (bus.req0_valid && bus.req1_valid) begin
          grant = pri;
        end else begin
          grant = bus.req1_valid;
        end
        req0_ready = bus.req0_valid && !grant && !RESET;
        req1_ready = bus.req1_valid &&  grant && !RESET;
        accept     = req0_ready || req1_ready;
        if (accept) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_next = CAPT;
        end
      end
      CAPT: begin
        state_next = RESP;
      end
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid =  owner;
        rsp_fire   = owner ? bus.rsp1_ready : bus.rsp0_ready;
        if (rsp_fire) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pri    <= 1'b0;
      owner  <= 1'b0;
      lat_a  <= '0;
      lat_b  <= '0;
      lat_op <= '0;
      result <= '0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        owner  <= grant;
        pri    <= !grant;
        lat_a  <= grant ? bus.req1_a  : bus.req0_a;
        lat_b  <= grant ? bus.req1_b  : bus.req0_b;
        lat_op <= grant ? bus.req1_op : bus.req0_op;
        cnt    <= CNT_LOAD;
      end else if ((state == EXEC) && (cnt != '0)) begin
        cnt <= cnt - CNT_ONE;
      end
      if (state == CAPT) begin
        result <= bus.alu_result;
      end
    end
  end

  assign bus.req0_ready  = req0_ready;
  assign bus.req1_ready  = req1_ready;
  assign bus.rsp0_valid  = rsp0_valid;
  assign bus.rsp1_valid  = rsp1_valid;
  assign bus.rsp_data    = result;
  assign bus.alu_in_a    = lat_a;
  assign bus.alu_in_b    = lat_b;
  assign bus.alu_op_code = lat_op;
  assign bus.busy        = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_scheduler.sv
`default_nettype none
// tb_alu_scheduler: randomized and directed checks of alu_scheduler against a cycle-count reference model.
// Rev 1.0
module tb_alu_scheduler;
  localparam int DW  = 8;
  localparam int OW  = 4;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_scheduler_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();
  alu_scheduler_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus3 ();

  alu_scheduler #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .ALU_LATENCY(LAT)) u_dut (
    .CLK(clk), .RESET(rst), .bus(bus)
  );
  alu_scheduler #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .ALU_LATENCY(3)) u_dut3 (
    .CLK(clk), .RESET(rst), .bus(bus3)
  );

  function automatic logic [7:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [3:0] op);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a * b;
      4'h3:    return a << 1;
      4'h4:    return a ^ b;
      4'h5:    return a & b;
      4'h6:    return a | b;
      default: return ~a;
    endcase
  endfunction

  logic [7:0] alu1_q;
  logic [7:0] alu3_q [3];
  always_ff @(posedge clk) begin
    if (rst) begin
      alu1_q    <= '0;
      alu3_q[0] <= '0;
      alu3_q[1] <= '0;
      alu3_q[2] <= '0;
    end else begin
      alu1_q    <= alu_fn(bus.alu_in_a, bus.alu_in_b, bus.alu_op_code);
      alu3_q[0] <= alu_fn(bus3.alu_in_a, bus3.alu_in_b, bus3.alu_op_code);
      alu3_q[1] <= alu3_q[0];
      alu3_q[2] <= alu3_q[1];
    end
  end
  assign bus.alu_result  = alu1_q;
  assign bus3.alu_result = alu3_q[2];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Requester-side stimulus: a pending op is held until the model sees it accepted.
  bit         p_valid [2];
  logic [7:0] p_a     [2];
  logic [7:0] p_b     [2];
  logic [3:0] p_op    [2];
  bit         r_rdy   [2];

  // Reference model: one op in flight, response window opens LAT+2 cycles after accept.
  int         cyc = 0;
  bit         m_busy = 0;
  bit         m_pri = 0;
  bit         m_owner = 0;
  bit         just_reset = 0;
  int         m_acc = 0;
  logic [7:0] m_a, m_b, m_exp;
  logic [3:0] m_op;
  int         n_rsp1_cyc = 0;
  int         acc_cyc [$];
  bit         acc_own [$];
  logic [7:0] rsp_data_log [$];
  bit         rsp_own_log  [$];

  task automatic set_req(int i, logic [7:0] a, logic [7:0] b, logic [3:0] op);
    p_valid[i] = 1'b1;
    p_a[i]     = a;
    p_b[i]     = b;
    p_op[i]    = op;
  endtask

  task automatic step();
    bit g, er0, er1;
    bus.req0_valid = p_valid[0];
    bus.req1_valid = p_valid[1];
    bus.req0_a     = p_a[0];
    bus.req0_b     = p_b[0];
    bus.req0_op    = p_op[0];
    bus.req1_a     = p_a[1];
    bus.req1_b     = p_b[1];
    bus.req1_op    = p_op[1];
    bus.rsp0_ready = r_rdy[0];
    bus.rsp1_ready = r_rdy[1];
    #1;
    if (bus.req0_ready || bus.req1_ready) begin
      acc_cyc.push_back(cyc);
      acc_own.push_back(bus.req1_ready);
    end
    if (bus.rsp1_valid) n_rsp1_cyc++;
    if (rst) begin
      m_busy     = 1'b0;
      m_pri      = 1'b0;
      just_reset = 1'b1;
    end else begin
      if (just_reset) begin
        check("reset_rsp_data", bus.rsp_data, 0);
        check("reset_alu_in_a", bus.alu_in_a, 0);
        check("reset_alu_in_b", bus.alu_in_b, 0);
        check("reset_alu_op",   bus.alu_op_code, 0);
        just_reset = 1'b0;
      end
      check("busy", bus.busy, m_busy);
      if (!m_busy) begin
        g   = (p_valid[0] && p_valid[1]) ? m_pri : p_valid[1];
        er0 = p_valid[0] && !g;
        er1 = p_valid[1] && g;
        check("req0_ready", bus.req0_ready, er0);
        check("req1_ready", bus.req1_ready, er1);
        check("idle_rsp0_valid", bus.rsp0_valid, 0);
        check("idle_rsp1_valid", bus.rsp1_valid, 0);
        if (er0 || er1) begin
          m_owner    = g;
          m_a        = p_a[g];
          m_b        = p_b[g];
          m_op       = p_op[g];
          m_exp      = alu_fn(m_a, m_b, m_op);
          m_acc      = cyc;
          m_pri      = !g;
          m_busy     = 1'b1;
          p_valid[g] = 1'b0;
        end
      end else begin
        check("busy_req0_ready", bus.req0_ready, 0);
        check("busy_req1_ready", bus.req1_ready, 0);
        check("alu_in_a", bus.alu_in_a, m_a);
        check("alu_in_b", bus.alu_in_b, m_b);
        check("alu_op",   bus.alu_op_code, m_op);
        if (cyc - m_acc < LAT + 2) begin
          check("early_rsp0_valid", bus.rsp0_valid, 0);
          check("early_rsp1_valid", bus.rsp1_valid, 0);
        end else begin
          check("rsp0_valid", bus.rsp0_valid, !m_owner);
          check("rsp1_valid", bus.rsp1_valid, m_owner);
          check("rsp_data",   bus.rsp_data, m_exp);
          if (r_rdy[m_owner]) begin
            m_busy = 1'b0;
            rsp_data_log.push_back(bus.rsp_data);
            rsp_own_log.push_back(m_owner);
          end
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    r_rdy[0] = 1'b1;
    r_rdy[1] = 1'b1;
    while (m_busy && t < 50) begin
      step();
      t++;
    end
    check("drain_timeout", m_busy, 0);
  endtask

  task automatic lat3_op(logic [7:0] a, logic [7:0] b, logic [3:0] op, logic [7:0] exp);
    bit got = 1'b0;
    int t = 0;
    int k = 1;
    bus3.rsp0_ready = 1'b1;
    bus3.req0_a     = a;
    bus3.req0_b     = b;
    bus3.req0_op    = op;
    bus3.req0_valid = 1'b1;
    while (!got && t < 20) begin
      #1;
      if (bus3.req0_ready) got = 1'b1;
      @(negedge clk);
      t++;
    end
    check("lat3_accept", got, 1);
    bus3.req0_valid = 1'b0;
    while (k < 20) begin
      #1;
      if (bus3.rsp0_valid) break;
      @(negedge clk);
      k++;
    end
    check("lat3_latency", k, 5);
    check("lat3_data", bus3.rsp_data, exp);
    check("lat3_rsp1_valid", bus3.rsp1_valid, 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n0, t, a_cyc;
    for (int i = 0; i < 2; i++) begin
      p_valid[i] = 1'b0;
      p_a[i]     = '0;
      p_b[i]     = '0;
      p_op[i]    = '0;
      r_rdy[i]   = 1'b1;
    end
    bus3.req0_valid = 1'b0;
    bus3.req1_valid = 1'b0;
    bus3.req0_a = '0; bus3.req0_b = '0; bus3.req0_op = '0;
    bus3.req1_a = '0; bus3.req1_b = '0; bus3.req1_op = '0;
    bus3.rsp0_ready = 1'b0;
    bus3.rsp1_ready = 1'b0;
    @(negedge clk);

    // Single operation
    do_reset();
    n0 = rsp_data_log.size();
    set_req(0, 8'd5, 8'd3, 4'h0);
    repeat (6) step();
    check("single_count", rsp_data_log.size() - n0, 1);
    if (rsp_data_log.size() > n0) begin
      check("single_data", rsp_data_log[n0], 8'h08);
      check("single_owner", rsp_own_log[n0], 0);
    end

    // Contention straight after reset
    do_reset();
    n0 = rsp_data_log.size();
    set_req(0, 8'd9, 8'd4, 4'h1);
    set_req(1, 8'd3, 8'd7, 4'h2);
    t = 0;
    while (rsp_data_log.size() < n0 + 2 && t < 30) begin
      step();
      t++;
    end
    check("contend_count", rsp_data_log.size() - n0, 2);
    if (rsp_data_log.size() >= n0 + 2) begin
      check("contend_first_owner",  rsp_own_log[n0], 0);
      check("contend_first_data",   rsp_data_log[n0], 8'h05);
      check("contend_second_owner", rsp_own_log[n0+1], 1);
      check("contend_second_data",  rsp_data_log[n0+1], 8'h15);
    end

    // Fairness with both requesters continuously valid
    do_reset();
    n0 = acc_cyc.size();
    t = 0;
    while (acc_cyc.size() < n0 + 8 && t < 100) begin
      for (int i = 0; i < 2; i++)
        if (!p_valid[i]) set_req(i, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
      step();
      t++;
    end
    check("fair_count", acc_cyc.size() - n0, 8);
    if (acc_cyc.size() >= n0 + 8) begin
      check("fair_first_owner", acc_own[n0], 0);
      for (int i = 1; i < 8; i++) begin
        check("fair_owner", acc_own[n0+i], i % 2);
        check("fair_spacing", acc_cyc[n0+i] - acc_cyc[n0+i-1], 4);
      end
    end
    p_valid[0] = 1'b0;
    p_valid[1] = 1'b0;
    drain();

    // Backpressure on requester 1 while requester 0 waits
    r_rdy[1] = 1'b0;
    set_req(1, 8'hFF, 8'h00, 4'h5);
    n0 = acc_cyc.size();
    step();
    check("bp_accept", acc_cyc.size() - n0, 1);
    a_cyc = (acc_cyc.size() > n0) ? acc_cyc[n0] : 0;
    set_req(0, 8'h11, 8'h22, 4'h4);
    n_rsp1_cyc = 0;
    repeat (7) step();
    check("bp_held_cycles", n_rsp1_cyc, 5);
    r_rdy[1] = 1'b1;
    step();
    step();
    check("bp_resume_count", acc_cyc.size() - n0, 2);
    if (acc_cyc.size() >= n0 + 2) begin
      check("bp_resume_cycle", acc_cyc[n0+1] - a_cyc, 9);
      check("bp_resume_owner", acc_own[n0+1], 0);
    end
    drain();

    // Reset while executing, then a normal requester-1 op
    n0 = rsp_data_log.size();
    set_req(1, 8'h40, 8'h02, 4'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    set_req(1, 8'h21, 8'h03, 4'h6);
    repeat (6) step();
    check("rstmid_count", rsp_data_log.size() - n0, 1);
    if (rsp_data_log.size() > n0) begin
      check("rstmid_owner", rsp_own_log[n0], 1);
      check("rstmid_data",  rsp_data_log[n0], 8'h23);
    end

    // Randomized traffic with occasional reset
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!p_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
        r_rdy[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    rst = 1'b0;
    p_valid[0] = 1'b0;
    p_valid[1] = 1'b0;
    drain();

    // Three-cycle ALU instance
    lat3_op(8'h80, 8'h00, 4'h3, 8'h00);
    lat3_op(8'h12, 8'h34, 4'h0, 8'h46);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
